// File: rtl/interval_scheduler_pkg.sv
// Shared types and helpers for interval_scheduler.
// Optional abort behaviour is enabled by defining ISCHED_ABORT_EN.
package interval_scheduler_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  // One-hot decode sized for the largest supported requester count.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'(8'd1 << idx);
  endfunction

endpackage

// File: rtl/interval_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
  import interval_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  int idx;

  // Scan from farthest to nearest so the nearest requester overrides.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % int'(N_REQ);
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_scheduler.sv
// Shares one interval counter among N_REQ requesters with round-robin grant.
// Define ISCHED_ABORT_EN to abort an interval when the granted req drops.
module interval_scheduler
  import interval_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned W     = DEF_W,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ*W-1:0] period,
  output logic             busy,
  output logic [IW-1:0]    grant_id,
  output logic [W-1:0]     cnt,
  output logic [N_REQ-1:0] done
);

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [W-1:0]   period_l;
  logic [IW-1:0]  winner;
  logic           winner_valid;
  logic [W-1:0]   win_period_c;
  logic           abort_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (winner),
    .valid  (winner_valid)
  );

  assign win_period_c = period[int'(winner)*W +: W];

`ifdef ISCHED_ABORT_EN
  assign abort_c = ~req[grant_id];
`else
  assign abort_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      grant_id <= '0;
      cnt      <= '0;
      done     <= '0;
      rr_ptr   <= '0;
      period_l <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (winner_valid) begin
            grant_id <= winner;
            // A zero period still yields one counting cycle.
            period_l <= (win_period_c == '0) ? W'(1) : win_period_c;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ST_COUNT;
            rr_ptr   <= (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
          end
        end
        ST_COUNT: begin
          if (abort_c) begin
            cnt   <= '0;
            state <= ST_ABORT;
          end else if (cnt == period_l - W'(1)) begin
            cnt   <= '0;
            done  <= N_REQ'(onehot8(3'(grant_id)));
            state <= ST_DONE;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_scheduler.sv
// Directed self-checking bench for interval_scheduler (N_REQ=4, W=16).
module tb_interval_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] period;
  logic           busy;
  logic [1:0]     grant_id;
  logic [W-1:0]   cnt;
  logic [N-1:0]   done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  interval_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .period   (period),
    .busy     (busy),
    .grant_id (grant_id),
    .cnt      (cnt),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    period = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || cnt !== '0 || done !== '0)
      $display("FAIL reset: busy=%b grant=%0d cnt=%0d done=%b, expected 0/0/0/0000",
               busy, grant_id, cnt, done);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    period[0 +: W] = 16'd5;
    req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      step();
      total_cnt++;
      if (busy !== 1'b1 || cnt !== W'(c - 1) || done !== 4'b0000)
        $display("FAIL basic_count c%0d: busy=%b cnt=%0d done=%b, expected 1/%0d/0000",
                 c, busy, cnt, done, c - 1);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (done !== 4'b0001 || busy !== 1'b1)
      $display("FAIL basic_done: done=%b busy=%b, expected 0001/1", done, busy);
    else pass_cnt++;
    req = '0;
    step();
    total_cnt++;
    if (busy !== 1'b0 || done !== 4'b0000)
      $display("FAIL basic_idle: busy=%b done=%b, expected 0/0000", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_done;
    int           order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < int'(N); i++) period[i*W +: W] = 16'd2;
    req = 4'b1111;
    for (int c = 1; c <= 19; c++) begin
      step();
      exp_done = '0;
      if (c % 4 == 3) exp_done = 4'(4'd1 << order[c / 4]);
      total_cnt++;
      if (done !== exp_done)
        $display("FAIL rr_done c%0d: done=%b, expected %b", c, done, exp_done);
      else pass_cnt++;
      if (c % 4 == 1) begin
        total_cnt++;
        if (grant_id !== 2'(order[c / 4]))
          $display("FAIL rr_grant c%0d: grant=%0d, expected %0d", c, grant_id, order[c / 4]);
        else pass_cnt++;
      end
    end
    req = '0;
  endtask

  task automatic test_zero_period();
    do_reset();
    period[0 +: W] = 16'd0;
    req = 4'b0001;
    step();
    total_cnt++;
    if (busy !== 1'b1 || cnt !== '0 || done !== 4'b0000)
      $display("FAIL zero_count: busy=%b cnt=%0d done=%b, expected 1/0/0000", busy, cnt, done);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done !== 4'b0001)
      $display("FAIL zero_done: done=%b, expected 0001", done);
    else pass_cnt++;
    req = '0;
    step();
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL zero_idle: busy=%b, expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_period_change();
    do_reset();
    period[0 +: W] = 16'd3;
    req = 4'b0001;
    step();
    period[0 +: W] = 16'd9;
    step();
    step();
    total_cnt++;
    if (done !== 4'b0000 || cnt !== 16'd2)
      $display("FAIL pchg_c3: done=%b cnt=%0d, expected 0000/2", done, cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done !== 4'b0001)
      $display("FAIL pchg_done: done=%b, expected 0001", done);
    else pass_cnt++;
    req = '0;
    step();
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    period[0 +: W] = 16'd5;
    req = 4'b0001;
    step();
    step();
    total_cnt++;
    if (cnt !== 16'd1 || busy !== 1'b1)
      $display("FAIL rmid_pre: cnt=%0d busy=%b, expected 1/1", cnt, busy);
    else pass_cnt++;
    reset = 1'b1;
    req   = '0;
    step();
    total_cnt++;
    if (busy !== 1'b0 || cnt !== '0 || done !== 4'b0000 || grant_id !== 2'd0)
      $display("FAIL rmid_post: busy=%b cnt=%0d done=%b grant=%0d, expected 0/0/0000/0",
               busy, cnt, done, grant_id);
    else pass_cnt++;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      total_cnt++;
      if (done !== 4'b0000 || busy !== 1'b0)
        $display("FAIL rmid_quiet c%0d: done=%b busy=%b, expected 0000/0", c, done, busy);
      else pass_cnt++;
    end
  endtask

`ifdef ISCHED_ABORT_EN
  task automatic test_abort();
    do_reset();
    period[0 +: W] = 16'd10;
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) step();
    total_cnt++;
    if (cnt !== 16'd3)
      $display("FAIL abort_pre: cnt=%0d, expected 3", cnt);
    else pass_cnt++;
    req = '0;
    step();
    total_cnt++;
    if (busy !== 1'b1 || done !== 4'b0000 || cnt !== '0)
      $display("FAIL abort_state: busy=%b done=%b cnt=%0d, expected 1/0000/0", busy, done, cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0 || done !== 4'b0000)
      $display("FAIL abort_idle: busy=%b done=%b, expected 0/0000", busy, done);
    else pass_cnt++;
    period[1*W +: W] = 16'd2;
    req = 4'b1111;
    step();
    total_cnt++;
    if (grant_id !== 2'd1)
      $display("FAIL abort_next: grant=%0d, expected 1", grant_id);
    else pass_cnt++;
    req = '0;
    step();
    step();
    step();
  endtask
`endif

  initial begin
    reset  = 1'b1;
    req    = '0;
    period = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_period();
    test_period_change();
    test_reset_mid_count();
`ifdef ISCHED_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
